// File: rtl/fd4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fd4_pkg
//  Purpose  : Shared types and constants for the fetch_decode4b control stage:
//             FSM state encoding, opcode map, ALU select codes, the bundle of
//             datapath control outputs and the instruction-length helper.
//  Options  : CALL_STACK_EN - makes opcode D (CALL) a 2-byte instruction.
//  Revision : 1.0 - initial release
// ============================================================================
package fd4_pkg;

    // FSM states
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        FETCH2 = 3'd2,
        TARGET = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    // Opcode map (instruction bits [7:4])
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_OUT   = 4'h5;
    localparam logic [3:0] OP_CMPI  = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'h7;
    localparam logic [3:0] OP_JC    = 4'h8;
    localparam logic [3:0] OP_JNC   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_JNZ   = 4'hB;
    localparam logic [3:0] OP_NOPC  = 4'hC;
    localparam logic [3:0] OP_CALL  = 4'hD;
    localparam logic [3:0] OP_RET   = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // ALU function select codes
    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_PASSB = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_NAND  = 3'b100;

    // Datapath control bundle
    typedef struct packed {
        logic [3:0] d0;
        logic       ea;
        logic       eb;
        logic       ec;
        logic [2:0] slct;
    } ctrl_t;

    // True when the opcode carries a second (target) byte
    function automatic logic is_two_byte_op(input logic [3:0] op);
        logic two;
        two = (op >= OP_JMP) && (op <= OP_JNZ);
`ifdef CALL_STACK_EN
        if (op == OP_CALL) begin
            two = 1'b1;
        end
`endif
        return two;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fd4_decode.sv
`default_nettype none
// ============================================================================
//  Module   : fd4_decode
//  Purpose  : Purely combinational instruction decoder. Maps the current FSM
//             state, the instruction byte and the latched flags onto the
//             datapath controls and the sequencing hints used by the FSM.
//  Ports    : state_i       - current FSM state
//             instr_i       - instruction byte ([7:4] opcode, [3:0] operand)
//             flag_c_i/z_i  - latched carry / zero flags
//             ctrl_o        - d0/ea/eb/ec/slct, non-zero only in EXEC
//             jump_taken_o  - load PC with the jump target (EXEC only)
//             is_two_byte_o - instruction has a target byte (any state)
//             upd_flags_o   - capture ALU flags at end of EXEC
//             halt_o        - enter HALT at end of EXEC
//             call_o/ret_o  - CALL / RET in EXEC (CALL_STACK_EN only)
//  Options  : CALL_STACK_EN
//  Revision : 1.0 - initial release
// ============================================================================
module fd4_decode
    import fd4_pkg::*;
(
    input  state_t     state_i,
    input  logic [7:0] instr_i,
    input  logic       flag_c_i,
    input  logic       flag_z_i,
    output ctrl_t      ctrl_o,
    output logic       jump_taken_o,
    output logic       is_two_byte_o,
    output logic       upd_flags_o,
`ifdef CALL_STACK_EN
    output logic       call_o,
    output logic       ret_o,
`endif
    output logic       halt_o
);

    logic [3:0] w_op;
    logic [3:0] w_imm;

    assign w_op  = instr_i[7:4];
    assign w_imm = instr_i[3:0];

    always_comb begin
        ctrl_o        = '0;
        jump_taken_o  = 1'b0;
        upd_flags_o   = 1'b0;
        halt_o        = 1'b0;
`ifdef CALL_STACK_EN
        call_o        = 1'b0;
        ret_o         = 1'b0;
`endif
        // Length is needed in DECODE, before the instruction reaches EXEC
        is_two_byte_o = is_two_byte_op(w_op);

        if (state_i == EXEC) begin
            case (w_op)
                OP_LDI, OP_ADDI, OP_SUBI, OP_NANDI: begin
                    ctrl_o.d0   = w_imm;
                    ctrl_o.ea   = 1'b1;
                    ctrl_o.ec   = 1'b1;
                    upd_flags_o = 1'b1;
                    case (w_op)
                        OP_LDI:  ctrl_o.slct = ALU_PASSB;
                        OP_ADDI: ctrl_o.slct = ALU_ADD;
                        OP_SUBI: ctrl_o.slct = ALU_SUB;
                        default: ctrl_o.slct = ALU_NAND;
                    endcase
                end
                OP_OUT: begin
                    ctrl_o.eb   = 1'b1;
                    ctrl_o.slct = ALU_PASSA;
                end
                OP_CMPI: begin
                    // Subtract for flags only; accumulator is not loaded
                    ctrl_o.d0   = w_imm;
                    ctrl_o.ea   = 1'b1;
                    ctrl_o.slct = ALU_SUB;
                    upd_flags_o = 1'b1;
                end
                OP_JMP: jump_taken_o = 1'b1;
                OP_JC:  jump_taken_o = flag_c_i;
                OP_JNC: jump_taken_o = ~flag_c_i;
                OP_JZ:  jump_taken_o = flag_z_i;
                OP_JNZ: jump_taken_o = ~flag_z_i;
`ifdef CALL_STACK_EN
                OP_CALL: begin
                    jump_taken_o = 1'b1;
                    call_o       = 1'b1;
                end
                OP_RET: ret_o = 1'b1;
`endif
                OP_HLT: halt_o = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_decode4b.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_decode4b
//  Purpose  : Fetch/decode control stage for the 4-bit accumulator datapath.
//             Reads instructions from a synchronous program ROM (data valid one
//             cycle after the address), sequences FETCH/DECODE/EXEC and, for
//             2-byte jumps, FETCH2/TARGET; drives the datapath controls for
//             exactly the EXEC cycle and keeps carry/zero flags.
//  Ports    : clk, reset (async, active-low), run (stall in FETCH when low)
//             prog_addr/prog_data   - ROM interface (prog_addr == pc)
//             alu_out/alu_carry     - ALU result/carry sampled at end of EXEC
//             d0, ea, eb, ec, slct  - datapath controls
//             pc, flag_c, flag_z, halted - status
//  Params   : ADDR_W (8..12) PC width, RESET_PC PC value after reset
//  Options  : CALL_STACK_EN - adds 2-byte CALL (D) and RET (E) with a
//             one-deep return register; otherwise D/E are 1-byte NOPs.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_decode4b
    import fd4_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 12,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    input  logic [3:0]        alu_out,
    input  logic              alu_carry,
    output logic [3:0]        d0,
    output logic              ea,
    output logic              eb,
    output logic              ec,
    output logic [2:0]        slct,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_c,
    output logic              flag_z,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        lo_q, lo_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
`ifdef CALL_STACK_EN
    logic [ADDR_W-1:0] ret_q, ret_d;
    logic              w_call;
    logic              w_ret;
`endif

    logic [7:0]        w_instr;
    logic [11:0]       w_target_full;
    logic [ADDR_W-1:0] w_target;
    ctrl_t             w_ctrl;
    logic              w_jump_taken;
    logic              w_two_byte;
    logic              w_upd_flags;
    logic              w_halt;

    // In DECODE the byte is still on the ROM bus; afterwards it lives in ir
    assign w_instr       = (state_q == DECODE) ? prog_data : ir_q;
    assign w_target_full = {ir_q[3:0], lo_q};
    assign w_target      = w_target_full[ADDR_W-1:0];

    fd4_decode u_decode (
        .state_i       (state_q),
        .instr_i       (w_instr),
        .flag_c_i      (flag_c_q),
        .flag_z_i      (flag_z_q),
        .ctrl_o        (w_ctrl),
        .jump_taken_o  (w_jump_taken),
        .is_two_byte_o (w_two_byte),
        .upd_flags_o   (w_upd_flags),
`ifdef CALL_STACK_EN
        .call_o        (w_call),
        .ret_o         (w_ret),
`endif
        .halt_o        (w_halt)
    );

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        lo_d     = lo_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
`ifdef CALL_STACK_EN
        ret_d    = ret_q;
`endif
        case (state_q)
            FETCH: begin
                if (run) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ir_d    = prog_data;
                pc_d    = pc_q + c_pc_one;
                state_d = w_two_byte ? FETCH2 : EXEC;
            end
            FETCH2: begin
                state_d = TARGET;
            end
            TARGET: begin
                lo_d    = prog_data;
                pc_d    = pc_q + c_pc_one;
                state_d = EXEC;
            end
            EXEC: begin
                if (w_jump_taken) begin
                    pc_d = w_target;
                end
`ifdef CALL_STACK_EN
                // pc already points past the target byte here
                if (w_call) begin
                    ret_d = pc_q;
                end
                if (w_ret) begin
                    pc_d = ret_q;
                end
`endif
                if (w_upd_flags) begin
                    flag_c_d = alu_carry;
                    flag_z_d = (alu_out == 4'd0);
                end
                state_d = w_halt ? HALT : FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            lo_q     <= 8'h00;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
`ifdef CALL_STACK_EN
            ret_q    <= RESET_PC;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            lo_q     <= lo_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
`ifdef CALL_STACK_EN
            ret_q    <= ret_d;
`endif
        end
    end

    // Controls decode straight from state, so reset (state=FETCH) kills ec at once
    assign d0        = w_ctrl.d0;
    assign ea        = w_ctrl.ea;
    assign eb        = w_ctrl.eb;
    assign ec        = w_ctrl.ec;
    assign slct      = w_ctrl.slct;
    assign prog_addr = pc_q;
    assign pc        = pc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign halted    = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode4b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_decode4b
//  Purpose  : Directed self-checking bench for fetch_decode4b with a
//             behavioural synchronous ROM and hand-driven ALU result/carry.
//  Options  : CALL_STACK_EN - selects the CALL/RET scenario instead of the
//             opcode-D-as-NOP scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode4b;

    logic        clk;
    logic        reset;
    logic        run;
    logic [11:0] prog_addr;
    logic [7:0]  prog_data;
    logic [3:0]  alu_out;
    logic        alu_carry;
    logic [3:0]  d0;
    logic        ea, eb, ec;
    logic [2:0]  slct;
    logic [11:0] pc;
    logic        flag_c, flag_z, halted;

    logic [7:0]  rom [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode4b #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .d0        (d0),
        .ea        (ea),
        .eb        (eb),
        .ec        (ec),
        .slct      (slct),
        .pc        (pc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid one cycle after the address
    always @(posedge clk) prog_data <= rom[prog_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] e_d0, input logic e_ea,
                              input logic e_eb, input logic e_ec, input logic [2:0] e_slct);
        check(tag, 32'({d0, ea, eb, ec, slct}), 32'({e_d0, e_ea, e_eb, e_ec, e_slct}));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        run       = 1'b0;
        alu_out   = 4'h0;
        alu_carry = 1'b0;
        reset     = 1'b0;
        step(2);
        reset     = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        run       = 1'b0;
        alu_out   = 4'h0;
        alu_carry = 1'b0;

        // ---------------- Scenario A: LDI, SUBI, JZ taken, HLT ----------------
        clear_rom();
        rom[12'h000] = 8'h15;               // LDI 5
        rom[12'h001] = 8'h35;               // SUBI 5
        rom[12'h002] = 8'hA0;               // JZ 0x040
        rom[12'h003] = 8'h40;
        rom[12'h040] = 8'hF0;               // HLT
        do_reset();
        check("rst_pc", 32'(pc), 32'h000);
        check("rst_addr", 32'(prog_addr), 32'h000);
        check("rst_flags", 32'({flag_c, flag_z, halted}), 32'b000);
        check_ctrl("rst_ctrl", 4'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        run = 1'b1;
        step(1);                             // DECODE
        check_ctrl("decode_idle", 4'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step(1);                             // EXEC LDI 5
        check_ctrl("ldi_ctrl", 4'h5, 1'b1, 1'b0, 1'b1, 3'b010);
        alu_out = 4'h5; alu_carry = 1'b0;
        step(1);
        check("ldi_pc", 32'(pc), 32'h001);
        check("ldi_z", 32'(flag_z), 32'd0);
        step(2);                             // EXEC SUBI 5
        check_ctrl("subi_ctrl", 4'h5, 1'b1, 1'b0, 1'b1, 3'b001);
        alu_out = 4'h0; alu_carry = 1'b0;
        step(1);
        check("subi_z", 32'(flag_z), 32'd1);
        check("subi_pc", 32'(pc), 32'h002);
        step(4);                             // EXEC JZ
        check("jz_exec_pc", 32'(pc), 32'h004);
        check_ctrl("jz_ctrl", 4'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        step(1);
        check("jz_taken_pc", 32'(pc), 32'h040);
        step(2);                             // EXEC HLT
        check("hlt_exec", 32'(halted), 32'd0);
        step(1);
        check("halted", 32'(halted), 32'd1);
        check("halt_pc", 32'(pc), 32'h041);
        run = 1'b0; step(2);
        run = 1'b1; step(2);
        check("halt_hold_pc", 32'(pc), 32'h041);
        check("halt_hold", 32'(halted), 32'd1);
        check_ctrl("halt_ctrl", 4'h0, 1'b0, 1'b0, 1'b0, 3'b000);

        // ---------------- Scenario B: branches, wrap, stall ----------------
        clear_rom();
        rom[12'h000] = 8'h15;               // LDI 5 (carry=1, z=0)
        rom[12'h001] = 8'h00;               // NOP
        rom[12'h002] = 8'hA0;               // JZ 0x040 (not taken)
        rom[12'h003] = 8'h40;
        rom[12'h004] = 8'h90;               // JNC 0x040 (not taken)
        rom[12'h005] = 8'h40;
        rom[12'h006] = 8'h80;               // JC 0x020 (taken)
        rom[12'h007] = 8'h20;
        rom[12'h020] = 8'hBF;               // JNZ 0xFFD (taken)
        rom[12'h021] = 8'hFD;
        rom[12'hFFD] = 8'h7F;               // JMP 0xFFF
        rom[12'hFFE] = 8'hFF;
        rom[12'hFFF] = 8'h00;               // NOP, pc wraps to 0
        do_reset();
        run = 1'b1;
        step(2);
        alu_out = 4'h5; alu_carry = 1'b1;
        step(1);
        alu_out = 4'h0; alu_carry = 1'b0;
        check("b_flags", 32'({flag_c, flag_z}), 32'b10);
        step(3);
        check("nop_pc", 32'(pc), 32'h002);
        step(5);
        check("jz_not_taken", 32'(pc), 32'h004);
        step(5);
        check("jnc_not_taken", 32'(pc), 32'h006);
        step(5);
        check("jc_taken", 32'(pc), 32'h020);
        step(5);
        check("jnz_taken", 32'(pc), 32'hFFD);
        step(5);
        check("jmp_fff", 32'(pc), 32'hFFF);
        step(3);
        check("pc_wrap", 32'(pc), 32'h000);
        run = 1'b0;
        step(4);
        check("stall_pc", 32'(pc), 32'h000);
        check("stall_addr", 32'(prog_addr), 32'h000);
        check_ctrl("stall_ctrl", 4'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        run = 1'b1;
        step(2);
        check_ctrl("resume_ldi", 4'h5, 1'b1, 1'b0, 1'b1, 3'b010);
        step(1);
        check("resume_pc", 32'(pc), 32'h001);

        // ---------------- Scenario C: ALU ops, flags, opcode D, reset in EXEC ----------------
        clear_rom();
        rom[12'h000] = 8'h2A;               // ADDI A
        rom[12'h001] = 8'h4C;               // NANDI C
        rom[12'h002] = 8'h63;               // CMPI 3
        rom[12'h003] = 8'h50;               // OUT
`ifdef CALL_STACK_EN
        rom[12'h004] = 8'h00;               // NOP
`else
        rom[12'h004] = 8'hD0;               // 1-byte NOP without call stack
`endif
        rom[12'h005] = 8'h27;               // ADDI 7
        do_reset();
        run = 1'b1;
        step(2);
        check_ctrl("addi_ctrl", 4'hA, 1'b1, 1'b0, 1'b1, 3'b011);
        alu_out = 4'hF; alu_carry = 1'b0;
        step(1);
        check("addi_flags", 32'({flag_c, flag_z}), 32'b00);
        step(2);
        check_ctrl("nand_ctrl", 4'hC, 1'b1, 1'b0, 1'b1, 3'b100);
        alu_out = 4'h0; alu_carry = 1'b0;
        step(1);
        check("nand_flags", 32'({flag_c, flag_z}), 32'b01);
        step(2);
        check_ctrl("cmpi_ctrl", 4'h3, 1'b1, 1'b0, 1'b0, 3'b001);
        alu_out = 4'h0; alu_carry = 1'b1;
        step(1);
        check("cmpi_flags", 32'({flag_c, flag_z}), 32'b11);
        step(2);
        check_ctrl("out_ctrl", 4'h0, 1'b0, 1'b1, 1'b0, 3'b000);
        alu_out = 4'h5; alu_carry = 1'b0;
        step(1);
        alu_out = 4'h0;
        check("out_flags_hold", 32'({flag_c, flag_z}), 32'b11);
        check("out_pc", 32'(pc), 32'h004);
        step(3);
        check("op_d_pc", 32'(pc), 32'h005);
        step(2);
        check_ctrl("addi7_ctrl", 4'h7, 1'b1, 1'b0, 1'b1, 3'b011);
        #2 reset = 1'b0;
        #1;
        check_ctrl("rst_exec_ctrl", 4'h0, 1'b0, 1'b0, 1'b0, 3'b000);
        check("rst_exec_pc", 32'(pc), 32'h000);
        check("rst_exec_flags", 32'({flag_c, flag_z, halted}), 32'b000);
        step(1);
        reset = 1'b1;
        step(2);
        check_ctrl("restart_addi", 4'hA, 1'b1, 1'b0, 1'b1, 3'b011);

`ifdef CALL_STACK_EN
        // ---------------- Scenario D: CALL / RET ----------------
        clear_rom();
        rom[12'h000] = 8'h70;               // JMP 0x010
        rom[12'h001] = 8'h10;
        rom[12'h010] = 8'hD1;               // CALL 0x100
        rom[12'h011] = 8'h00;
        rom[12'h100] = 8'hE0;               // RET
        do_reset();
        run = 1'b1;
        step(5);
        check("call_setup_pc", 32'(pc), 32'h010);
        step(5);
        check("call_pc", 32'(pc), 32'h100);
        step(3);
        check("ret_pc", 32'(pc), 32'h012);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode4b.md
Name: fetch_decode4b

Overview:
- Upstream control stage for the 4-bit accumulator datapath: bus drivers, ALU and accumulator.
- Fetches 8-bit instructions from a synchronous program ROM and decodes them.
- Drives the datapath controls: operand nibble, bus-driver enables, ALU select and accumulator enable.
- Keeps carry/zero flags for conditional jumps.
- Multi-cycle FSM: FETCH, DECODE, EXEC for 1-byte instructions, plus FETCH2 and TARGET for 2-byte jumps.

Parameters:
ADDR_W, 12, program counter / ROM address width (8..12); jump targets use the low ADDR_W bits.
RESET_PC, 0, PC value after reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  FSM leaves FETCH only while high; stall otherwise
prog_addr  out  ADDR_W  ROM address; data valid one cycle later
prog_data  in  8  ROM instruction byte: [7:4] opcode, [3:0] operand
alu_out  in  4  ALU result, sampled at end of EXEC
alu_carry  in  1  ALU carry, sampled at end of EXEC
d0  out  4  operand nibble to operand bus driver
ea  out  1  operand bus-driver enable
eb  out  1  output bus-driver enable
ec  out  1  accumulator load enable
slct  out  3  ALU function select
pc  out  ADDR_W  current program counter
flag_c  out  1  latched carry
flag_z  out  1  latched zero
halted  out  1  high in HALT state

Behaviour:
- Reset (reset=0, asynchronous): state=FETCH, pc=RESET_PC, ir=0, lo=0, flag_c=0, flag_z=0, halted=0.
- While in reset, d0/ea/eb/ec/slct are all 0.
- prog_addr = pc at all times.
- FETCH: if run=1, go to DECODE; else hold. ROM is addressed by pc.
- DECODE: ir<=prog_data; pc<=pc+1.
  - Opcode 7..B, and D when CALL_STACK_EN is set: go to FETCH2.
  - Otherwise: go to EXEC.
- FETCH2: go to TARGET.
- TARGET: lo<=prog_data; pc<=pc+1; go to EXEC. Target = {ir[3:0],lo}[ADDR_W-1:0].
- EXEC: control outputs are active for exactly this one cycle. Outside EXEC: d0=0, ea=eb=ec=0, slct=000. Next state is FETCH, or HALT for opcode F.
- Opcode map (EXEC outputs):
  - 0 NOP: none.
  - 1 LDI: d0=op, ea=1, slct=010, ec=1.
  - 2 ADDI: as LDI but slct=011.
  - 3 SUBI: as LDI but slct=001.
  - 4 NANDI: as LDI but slct=100.
  - 5 OUT: slct=000, eb=1.
  - 6 CMPI: d0=op, ea=1, slct=001, ec=0.
  - 7 JMP: pc<=target.
  - 8 JC: jump if flag_c=1.
  - 9 JNC: jump if flag_c=0.
  - A JZ: jump if flag_z=1.
  - B JNZ: jump if flag_z=0.
  - C: NOP.
  - D/E: see Optional Feature.
  - F HLT: go to HALT.
- Flags: at the end of EXEC for opcodes 1,2,3,4,6: flag_c<=alu_carry, flag_z<=(alu_out==0). All other opcodes hold the flags. The zero flag is computed here; the ALU's zero output is not used.
- Conditional jump not taken: pc keeps its post-operand value (next instruction).
- Latency: 1-byte instruction = 3 cycles; 2-byte = 5 cycles (with run held high).
- PC increments wrap modulo 2^ADDR_W.
- HALT: halted=1, controls idle. Only reset exits HALT.
- run=0 takes effect only in FETCH; an instruction already in flight completes.
- Reset mid-instruction aborts it; no partial ec pulse is permitted after reset asserts.

Optional Feature:
- Macro: CALL_STACK_EN.
- Defined:
  - D CALL is 2-byte: ret_reg<=pc (already past the operand), then pc<=target.
  - E RET: pc<=ret_reg.
  - One-deep stack; a nested CALL overwrites ret_reg. ret_reg resets to RESET_PC.
- Undefined: D and E are 1-byte NOPs and no ret_reg exists.

Decomposition:
- Package fd4_pkg holds:
  - state enum: FETCH, DECODE, FETCH2, TARGET, EXEC, HALT;
  - opcode localparams OP_NOP..OP_HLT;
  - ALU select constants ALU_PASSA=000, ALU_SUB=001, ALU_PASSB=010, ALU_ADD=011, ALU_NAND=100.
- One sub-module, fd4_decode: purely combinational; maps {state, ir, flags} to control outputs, jump_taken and is_two_byte.

Test Plan:
- Reset then run=1, ROM[0]=0x15 (LDI 5) -> EXEC at cycle 3: d0=5, ea=1, slct=010, ec=1. With alu_out=5: flag_z=0, pc=1.
- ROM[1]=0x35 (SUBI 5) with alu_out=0, alu_carry=0 -> flag_z=1. Next ROM[2..3]=0xA0,0x40 (JZ 0x040) -> pc=0x040 after 5 cycles.
- flag_z=0 and JZ 0x040 at address 2 -> not taken, pc=4. JMP 0xFFF at addr 0xFFE -> pc=0xFFF; the following NOP wraps pc to 0x000.
- run held 0 for 4 cycles in FETCH -> pc unchanged and all controls 0. run=1 -> normal sequence resumes.
- HLT (0xF0) -> halted=1, pc frozen, run toggling ignored. Reset asserted during EXEC of ADDI -> ec drops immediately, pc=0, state=FETCH.
- CALL_STACK_EN defined: CALL 0x100 at 0x010, then RET at 0x100 -> pc=0x012. Macro undefined: 0xD0 advances pc by exactly 1.
